// File: rtl/micro_sequencer.sv
// micro_sequencer: microcode next-address generator with instruction register, memory-wait stalls and HALT parking.
// Optional SEQ_TIMEOUT_EN adds a stall watchdog that forces RESET_ADDR after WAIT_LIMIT stalled cycles.
module micro_sequencer #(
    parameter int ADDR_W = 9,
    parameter int CW_W = 39,
    parameter logic [ADDR_W-1:0] RESET_ADDR = 9'b000000000,
    parameter logic [ADDR_W-1:0] HALT_ADDR = 9'b011111111,
    parameter int WAIT_LIMIT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [CW_W-1:0]   ctrl_word,
    input  logic              z_flag,
    input  logic              hit,
    input  logic [15:0]       ins_data,
    output logic [ADDR_W-1:0] addr_ins,
    output logic [3:0]        operand1,
    output logic [3:0]        operand2,
    output logic              mem_stall,
    output logic              halted,
    output logic              mem_timeout
);
    logic [12:0] ir;
    logic [4:0] nop, op;
    logic [2:0] nstep, cond, memc;
    logic fetch, dread, hold, active, tmo;
    logic [ADDR_W-1:0] next;
    logic unused_bits;

    assign unused_bits = ^{ctrl_word[27:3], ins_data[15:13]};
    assign operand1 = ir[7:4];
    assign operand2 = ir[3:0];

    always_comb begin
        nop = ctrl_word[38:34];
        nstep = ctrl_word[33:31];
        cond = ctrl_word[30:28];
        memc = ctrl_word[2:0];
        fetch = memc == 3'b001;
        dread = memc == 3'b010;
        hold = (fetch || dread) && !hit;
        // a completing fetch decodes the opcode arriving on ins_data, not the stale IR
        op = fetch ? ins_data[12:8] : ir[12:8];
        next = dread ? {1'b1, nop, nstep}
             : cond == 3'b001 ? {~z_flag, nop, nstep}
             : cond == 3'b100 ? {1'b0, op, 3'b000}
             : {1'b0, nop, nstep};
        active = en && !halted && addr_ins != HALT_ADDR;
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_LIMIT - 1);
    logic [CNT_W-1:0] cnt;

    assign tmo = hold && cnt == LAST;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            mem_timeout <= 1'b0;
        end else if (active) begin
            cnt <= (hold && !tmo) ? cnt + 1'b1 : '0;
            if (tmo) mem_timeout <= 1'b1;
        end
    end
`else
    logic unused_lim;
    assign unused_lim = WAIT_LIMIT[0];
    assign tmo = 1'b0;
    assign mem_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_ins <= RESET_ADDR;
            ir <= '0;
            mem_stall <= 1'b0;
            halted <= 1'b0;
        end else if (en && !halted) begin
            if (addr_ins == HALT_ADDR) begin
                halted <= 1'b1;
            end else if (tmo) begin
                addr_ins <= RESET_ADDR;
                mem_stall <= 1'b0;
            end else if (hold) begin
                mem_stall <= 1'b1;
            end else begin
                addr_ins <= next;
                mem_stall <= 1'b0;
                if (fetch) ir <= ins_data[12:0];
            end
        end
    end
endmodule
